// File: rtl/rename_pkg.sv
// rtl/rename_pkg.sv - shared types and sizes for the register-rename stage
package rename_pkg;

   localparam int ARCH_REGS = 32;
   localparam int PHYS_REGS = 64;
   localparam int PTAG_W    = $clog2(PHYS_REGS);
   localparam int AREG_W    = $clog2(ARCH_REGS);
   localparam int CNT_W     = PTAG_W + 1;

   typedef logic [PTAG_W-1:0] ptag_t;
   typedef logic [AREG_W-1:0] areg_t;
   typedef logic [CNT_W-1:0]  fl_cnt_t;

   typedef struct packed {
      ptag_t psrc1;
      ptag_t psrc2;
      ptag_t pdest;
      ptag_t old_pdest;
   } ren_pkt_t;

   // Tags ARCH_REGS..PHYS_REGS-1 are free out of reset; the rest back the identity RAT.
   localparam fl_cnt_t FL_INIT_COUNT = fl_cnt_t'(PHYS_REGS - ARCH_REGS);
   localparam fl_cnt_t FL_MAX_COUNT  = fl_cnt_t'(PHYS_REGS - 1);
   localparam ptag_t   FL_INIT_TAIL  = ptag_t'(PHYS_REGS - ARCH_REGS);

   // Circular pointer increment; explicit wrap keeps it correct for non-power-of-two depths.
   function automatic ptag_t ptr_next(input ptag_t p);
      if (p == ptag_t'(PHYS_REGS - 1)) begin
         return '0;
      end
      return p + ptag_t'(1);
   endfunction

endpackage

// File: rtl/rename_stage_if.sv
// rtl/rename_stage_if.sv - dispatch, renamed-packet and retire signals of the rename stage
interface rename_stage_if
   import rename_pkg::*;
();

   logic  dispatch_valid;
   areg_t srcReg1_in;
   areg_t srcReg2_in;
   areg_t destReg_in;
   logic  regWrite_in;
   logic  ren_ready;
   logic  retire_valid;
   ptag_t retire_tag;

   logic  ren_valid;
   ptag_t ren_psrc1;
   ptag_t ren_psrc2;
   ptag_t ren_pdest;
   ptag_t ren_old_pdest;
   logic  rename_stall;

   // The rename stage itself.
   modport slave (
      input  dispatch_valid, srcReg1_in, srcReg2_in, destReg_in, regWrite_in,
      input  ren_ready, retire_valid, retire_tag,
      output ren_valid, ren_psrc1, ren_psrc2, ren_pdest, ren_old_pdest, rename_stall
   );

   // Front end, dispatch and ROB side.
   modport master (
      output dispatch_valid, srcReg1_in, srcReg2_in, destReg_in, regWrite_in,
      output ren_ready, retire_valid, retire_tag,
      input  ren_valid, ren_psrc1, ren_psrc2, ren_pdest, ren_old_pdest, rename_stall
   );

endinterface

// File: rtl/rename_stage_free_list_fifo.sv
// rtl/rename_stage_free_list_fifo.sv - circular FIFO of free physical tags
module free_list_fifo
   import rename_pkg::*;
(
   input  logic    clk,
   input  logic    rstn,
   input  logic    i_push,
   input  ptag_t   i_push_tag,
   input  logic    i_pop,
   output ptag_t   o_head_tag,
   output fl_cnt_t o_count
);

   ptag_t   r_mem [PHYS_REGS];
   ptag_t   r_head;
   ptag_t   r_tail;
   fl_cnt_t r_count;

   logic w_push;
   logic w_pop;

   // Tag 0 backs x0 and must never re-enter circulation.
   assign w_push = i_push && (i_push_tag != '0);
   // The caller only pops when the registered count is non-zero; the guard keeps pointers sane anyway.
   assign w_pop  = i_pop && (r_count != '0);

   // Storage, pointers and occupancy; reset reloads the ascending tag sequence.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int i = 0; i < PHYS_REGS; i++) begin
            r_mem[i] <= (i < PHYS_REGS - ARCH_REGS) ? ptag_t'(ARCH_REGS + i) : '0;
         end
         r_head  <= '0;
         r_tail  <= FL_INIT_TAIL;
         r_count <= FL_INIT_COUNT;
      end else begin
         if (w_push) begin
            r_mem[r_tail] <= i_push_tag;
            r_tail        <= ptr_next(r_tail);
         end
         if (w_pop) begin
            r_head <= ptr_next(r_head);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + fl_cnt_t'(1);
            2'b01:   r_count <= r_count - fl_cnt_t'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Head is read straight from storage; a same-cycle push lands at the tail and is never bypassed.
   assign o_head_tag = r_mem[r_head];
   assign o_count    = r_count;

   // A push into a list already holding PHYS_REGS-1 tags means the ROB returned a tag twice.
   a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
      !(w_push && (r_count == FL_MAX_COUNT)));

   // The rename stage must stall rather than pop an empty list.
   a_no_underflow: assert property (@(posedge clk) disable iff (!rstn)
      !(i_pop && (r_count == '0)));

endmodule

// File: rtl/rename_stage.sv
// rtl/rename_stage.sv - RAT lookup, tag allocation and registered renamed packet
module rename_stage
   import rename_pkg::*;
(
   input  logic          clk,
   input  logic          rstn,
   rename_stage_if.slave bus
);

   ptag_t    r_rat [ARCH_REGS];
   logic     r_valid;
   ren_pkt_t r_pkt;

   logic     w_need;
   logic     w_hold;
   logic     w_stall;
   logic     w_acc;
   logic     w_alloc;
   ptag_t    w_head_tag;
   fl_cnt_t  w_fl_count;
   ptag_t    w_psrc1;
   ptag_t    w_psrc2;
   ren_pkt_t w_next_pkt;

   // x0 is never renamed, so only writes to a real register consume a tag.
   assign w_need  = bus.regWrite_in && (bus.destReg_in != '0);
   // Downstream has not taken the packet we are already presenting.
   assign w_hold  = r_valid && !bus.ren_ready;
   // Uses the count registered at cycle start, so a same-cycle retire cannot rescue an empty list.
   assign w_stall = bus.dispatch_valid && ((w_need && (w_fl_count == '0)) || w_hold);
   assign w_acc   = bus.dispatch_valid && !w_stall;
   assign w_alloc = w_acc && w_need;

   // Source lookups see the RAT as it stood before this cycle's update.
   assign w_psrc1 = (bus.srcReg1_in == '0) ? '0 : r_rat[bus.srcReg1_in];
   assign w_psrc2 = (bus.srcReg2_in == '0) ? '0 : r_rat[bus.srcReg2_in];

   free_list_fifo u_free_list (
      .clk        (clk),
      .rstn       (rstn),
      .i_push     (bus.retire_valid),
      .i_push_tag (bus.retire_tag),
      .i_pop      (w_alloc),
      .o_head_tag (w_head_tag),
      .o_count    (w_fl_count)
   );

   // Assemble the packet that will be registered if this instruction is accepted.
   always_comb begin
      w_next_pkt           = '0;
      w_next_pkt.psrc1     = w_psrc1;
      w_next_pkt.psrc2     = w_psrc2;
      if (w_need) begin
         w_next_pkt.pdest     = w_head_tag;
         w_next_pkt.old_pdest = r_rat[bus.destReg_in];
      end
   end

   // RAT: identity after reset; an allocating accept remaps rd to the popped tag.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int i = 0; i < ARCH_REGS; i++) begin
            r_rat[i] <= ptag_t'(i);
         end
      end else if (w_alloc) begin
         r_rat[bus.destReg_in] <= w_head_tag;
      end
   end

   // Output register: load on accept, drop valid once drained, hold everything while back-pressured.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_valid <= 1'b0;
         r_pkt   <= '0;
      end else if (w_acc) begin
         r_valid <= 1'b1;
         r_pkt   <= w_next_pkt;
      end else if (bus.ren_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign bus.ren_valid     = r_valid;
   assign bus.ren_psrc1     = r_pkt.psrc1;
   assign bus.ren_psrc2     = r_pkt.psrc2;
   assign bus.ren_pdest     = r_pkt.pdest;
   assign bus.ren_old_pdest = r_pkt.old_pdest;
   assign bus.rename_stall  = w_stall;

endmodule
